// File: rtl/seg_scan_decoder_if.sv
// Multiplexed 7-segment scan bus: active-low segments and digit selects.
// The scan driver is the master, the decoder the slave.
interface seg_scan_decoder_if;
    logic [7:0] segment;
    logic [7:0] select;

    modport master (
        output segment,
        output select
    );

    modport slave (
        input segment,
        input select
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Scan-bus receiver: samples each settled digit select and rebuilds
// an 8-digit hex frame with dp, blank and error flags per position.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 16,
    parameter int FRAME_TIMEOUT = 1000000,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_scan_decoder_if.slave    bus,
    output logic [31:0]          digits,
    output logic [7:0]           dp_out,
    output logic [7:0]           blank_mask,
    output logic [7:0]           err_mask,
    output logic                 frame_valid,
    output logic                 select_err,
    output logic                 timeout,
    output logic [CNT_W-1:0]     frame_count
);

    localparam int TW = $clog2(FRAME_TIMEOUT + 1);

    logic [7:0]    r_seg_q;
    logic [7:0]    r_sel_q;
    logic [7:0]    r_sel_d;
    logic [7:0]    r_dwell;
    logic          r_sampled;
    logic [7:0]    r_seen;
    logic [TW-1:0] r_timer;
    logic [31:0]   r_sh_nib;
    logic [7:0]    r_sh_dp;
    logic [7:0]    r_sh_blank;
    logic [7:0]    r_sh_err;

    logic [7:0] w_low;
    logic       w_same;
    logic       w_hit;
    logic       w_one;
    logic       w_none;
    logic       w_store;
    logic       w_selerr;
    logic [7:0] w_seen_set;
    logic       w_full;
    logic       w_last;
    logic       w_expire;
    logic [5:0] w_dec;

    // Returns {err, blank, nibble} for the seven segment lines.
    function automatic logic [5:0] f_decode(input logic [6:0] s);
        case (s)
            7'h40:   return 6'h00;
            7'h79:   return 6'h01;
            7'h24:   return 6'h02;
            7'h30:   return 6'h03;
            7'h19:   return 6'h04;
            7'h12:   return 6'h05;
            7'h02:   return 6'h06;
            7'h78:   return 6'h07;
            7'h00:   return 6'h08;
            7'h10:   return 6'h09;
            7'h08:   return 6'h0A;
            7'h03:   return 6'h0B;
            7'h46:   return 6'h0C;
            7'h21:   return 6'h0D;
            7'h06:   return 6'h0E;
            7'h0E:   return 6'h0F;
            7'h7F:   return 6'h10;
            default: return 6'h2F;
        endcase
    endfunction

    assign w_low      = ~r_sel_q;
    assign w_same     = (r_sel_q == r_sel_d);
    assign w_hit      = w_same && !r_sampled &&
                        (r_dwell == 8'(SETTLE_CYCLES - 1));
    assign w_none     = (w_low == 8'd0);
    assign w_one      = !w_none && ((w_low & (w_low - 8'd1)) == 8'd0);
    assign w_store    = w_hit && w_one;
    assign w_selerr   = w_hit && !w_none && !w_one;
    assign w_seen_set = r_seen | (w_store ? w_low : 8'd0);
    assign w_full     = (r_seen == 8'hFF);
    assign w_last     = w_store && (w_seen_set == 8'hFF);
    // A frame finishing in the expiry cycle takes priority over the timeout.
    assign w_expire   = (r_seen != 8'd0) && !w_full && !w_last &&
                        (r_timer == TW'(FRAME_TIMEOUT - 1));
    assign w_dec      = f_decode(r_seg_q[6:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_q     <= 8'hFF;
            r_sel_q     <= 8'hFF;
            r_sel_d     <= 8'hFF;
            r_dwell     <= 8'd0;
            r_sampled   <= 1'b0;
            r_seen      <= 8'd0;
            r_timer     <= '0;
            r_sh_nib    <= 32'd0;
            r_sh_dp     <= 8'd0;
            r_sh_blank  <= 8'd0;
            r_sh_err    <= 8'd0;
            digits      <= 32'd0;
            dp_out      <= 8'd0;
            blank_mask  <= 8'd0;
            err_mask    <= 8'd0;
            frame_valid <= 1'b0;
            select_err  <= 1'b0;
            timeout     <= 1'b0;
            frame_count <= '0;
        end else begin
            r_seg_q     <= bus.segment;
            r_sel_q     <= bus.select;
            r_sel_d     <= r_sel_q;
            select_err  <= w_selerr;
            frame_valid <= w_full;
            timeout     <= w_expire;

            if (!w_same) begin
                r_dwell   <= 8'd0;
                r_sampled <= 1'b0;
            end else begin
                if (r_dwell != 8'(SETTLE_CYCLES))
                    r_dwell <= r_dwell + 8'd1;
                if (w_hit)
                    r_sampled <= 1'b1;
            end

            for (int i = 0; i < 8; i++) begin
                if (w_store && w_low[i]) begin
                    r_sh_nib[4*i +: 4] <= w_dec[3:0];
                    r_sh_blank[i]      <= w_dec[4];
                    r_sh_err[i]        <= w_dec[5];
                    r_sh_dp[i]         <= ~r_seg_q[7];
                end
            end

            if (w_full || w_expire) begin
                r_seen  <= w_store ? w_low : 8'd0;
                r_timer <= '0;
            end else begin
                r_seen <= w_seen_set;
                if (r_seen != 8'd0)
                    r_timer <= r_timer + 1'b1;
            end

            if (w_full) begin
                digits      <= r_sh_nib;
                dp_out      <= r_sh_dp;
                blank_mask  <= r_sh_blank;
                err_mask    <= r_sh_err;
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed 7-segment scan driver in top. Samples the active-low segment/select bus and decodes each scanned pattern back to a hex digit per position. Assembles a full 8-digit frame for self-checking benches and for on-chip loopback checks of the display path. Runs on the 50 MHz system clock in the same domain as the scan driver.

Parameters:
SETTLE_CYCLES, 16, consecutive cycles select must be unchanged before segment is sampled (legal range 2..255)
FRAME_TIMEOUT, 1000000, cycles allowed to complete a frame before the partial frame is discarded
CNT_W, 16, width of frame_count

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
segment  input  8  {dp,g,f,e,d,c,b,a}, active-low (0 = lit)
select  input  8  digit enables, active-low one-hot; bit i = digit position i
digits  output  32  frame digits; digits[4i+3:4i] = position i
dp_out  output  8  decimal point per position, 1 = lit
blank_mask  output  8  1 = position sampled as all-off (segment[6:0]=7'h7F)
err_mask  output  8  1 = position sampled with an undecodable pattern
frame_valid  output  1  one-cycle pulse when digits/dp_out/masks update
select_err  output  1  one-cycle pulse when a settled select has more than one bit low
timeout  output  1  one-cycle pulse when FRAME_TIMEOUT expires
frame_count  output  CNT_W  completed frames, wraps at 2^CNT_W

Behaviour:
- Reset, asynchronous: all outputs 0. Internal sel_q=8'hFF, seg_q=8'hFF, dwell=0, sampled=0, seen=0, timer=0.
- Input stage: segment and select are registered once into seg_q/sel_q. All decisions use the registered copies.
- Dwell: if sel_q differs from its previous value, dwell=0 and sampled=0. Otherwise dwell increments and saturates at SETTLE_CYCLES.
- Sample event: fires once per dwell, in the cycle dwell reaches SETTLE_CYCLES with sampled=0. Then sampled=1.
  - sel_q=8'hFF (blanked): no action.
  - More than one bit low: select_err pulses the next cycle. No store.
  - Exactly one bit low at position p: decode seg_q into shadow slot p and set seen[p].
- Decode of seg_q[6:0] into the shadow slot:
  - Patterns 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E map to 0..F.
  - 7F: nibble 0, blank=1.
  - Any other pattern: nibble F, err=1.
  - dp = ~seg_q[7].
- Re-sampling a position already in seen overwrites its slot. No error is raised.
- Frame complete: the cycle after seen becomes 8'hFF:
  - Shadow copies to digits/dp_out/blank_mask/err_mask.
  - frame_valid pulses and frame_count increments (wraps).
  - seen and timer clear.
  - Outputs hold their values between frames.
- Timer: increments every cycle while seen is non-zero. At FRAME_TIMEOUT-1, timeout pulses, seen clears and timer clears. Outputs are not updated.
- Simultaneous cases:
  - Timeout expiry and the 8th sample in the same cycle: the sample wins, no timeout.
  - A select change during the sample cycle: the sample uses that cycle's sel_q/seg_q.
- Reset mid-frame discards the partial frame immediately.
- Latency: a new select value settled on the pins is sampled SETTLE_CYCLES+1 clocks later.

Test Plan:
- Reset with rst_n=0 mid-scan (100 µs) -> all outputs 0; frame_count=0; no pulses until the first full frame after release.
- Scan positions 0..7 with patterns C0,F9,A4,B0,99,92,82,F8, 1000 cycles each -> one frame_valid; digits=32'h76543210, dp_out=0, masks=0, frame_count=1.
- Dwell-length check on position 3:
  - Pattern 0x06 (dp lit) held 10 cycles then 20 cycles, SETTLE_CYCLES=16 -> only the 20-cycle dwell samples.
  - After frame completes: digit 3 = E, dp_out[3]=1.
- select=8'b1111_0011 held 100 cycles -> exactly one select_err pulse; seen unchanged; no frame_valid.
- Position 5 driven 8'hFF, position 6 driven 8'hD5 (plus valid other positions) -> blank_mask=8'h20, err_mask=8'h40, digit 6 = F.
- Only positions 0..6 scanned, then select idle 8'hFF -> timeout pulse at FRAME_TIMEOUT; no frame_valid.
  - A later full scan still yields frame_valid with frame_count incremented by 1.
